object_renderer: RTL and testbench

//  Consumer side of the ball/shot position interface from the game-state controller.

---
 rtl/object_renderer.sv | 204 ++++++++++++++++++++
 tb/tb_object_renderer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/object_renderer.sv
// object_renderer: classifies each scanned pixel against the per-frame snapshot
// of ball discs and shot boxes, and reports which balls were visible last frame.
//
// Stream semantics: pix_valid/out_valid form a valid-only stream with no ready.
// Every cycle with pix_valid=1 is one pixel, and it emerges exactly 3 cycles
// later with out_valid=1. Bubbles pass through unchanged and nothing ever stalls.
module object_renderer #(
  parameter int BALL_NUM = 3,
  parameter int SHOT_NUM = 2,
  parameter int SHOT_HW  = 2,
  parameter int SHOT_HH  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [9:0]               px,
  input  logic [9:0]               py,
  input  logic [5:0]               radius,
  input  logic [BALL_NUM*10-1:0]   i_bx,
  input  logic [BALL_NUM*10-1:0]   i_by,
  input  logic [BALL_NUM-1:0]      b_active,
  input  logic [SHOT_NUM*10-1:0]   i_sx,
  input  logic [SHOT_NUM*10-1:0]   i_sy,
  input  logic [SHOT_NUM-1:0]      s_active,
  output logic                     out_valid,
  output logic [9:0]               o_px,
  output logic [9:0]               o_py,
  output logic                     ball_hit,
  output logic [1:0]               ball_idx,
  output logic                     shot_hit,
  output logic                     shot_idx,
  output logic [BALL_NUM-1:0]      b_seen
);

  localparam logic [9:0] SHW = 10'(SHOT_HW);
  localparam logic [9:0] SHH = 10'(SHOT_HH);

  // Shadow copy of the object state, refreshed once per frame
  logic [5:0]             snap_r;
  logic [BALL_NUM*10-1:0] snap_bx, snap_by;
  logic [BALL_NUM-1:0]    snap_ba;
  logic [SHOT_NUM*10-1:0] snap_sx, snap_sy;
  logic [SHOT_NUM-1:0]    snap_sa;

  // Stage 1: deltas plus the flags/radius the pixel entered with
  logic                pv1;
  logic [9:0]          px1, py1;
  logic [5:0]          r1;
  logic [BALL_NUM-1:0] ba1;
  logic [SHOT_NUM-1:0] sa1;
  logic [9:0]          bdx1 [BALL_NUM];
  logic [9:0]          bdy1 [BALL_NUM];
  logic [9:0]          sdx1 [SHOT_NUM];
  logic [9:0]          sdy1 [SHOT_NUM];

  // Stage 2: squared distances, squared radius, shot box tests
  logic                pv2;
  logic [9:0]          px2, py2;
  logic [11:0]         rr2;
  logic [BALL_NUM-1:0] ba2;
  logic [20:0]         sum2 [BALL_NUM];
  logic [SHOT_NUM-1:0] s_in2;

  // Stage 3 combinational results
  logic [BALL_NUM-1:0] b_in3;
  logic [1:0]          b_idx3;
  logic                s_idx3;

  // Seen accumulator for the frame in progress
  logic [BALL_NUM-1:0] seen_acc;

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Latch the object state on frame_start; used from the following cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_r  <= '0;
      snap_bx <= '0;
      snap_by <= '0;
      snap_ba <= '0;
      snap_sx <= '0;
      snap_sy <= '0;
      snap_sa <= '0;
    end else if (frame_start) begin
      snap_r  <= radius;
      snap_bx <= i_bx;
      snap_by <= i_by;
      snap_ba <= b_active;
      snap_sx <= i_sx;
      snap_sy <= i_sy;
      snap_sa <= s_active;
    end
  end

  // Stage 1: absolute deltas against the current snapshot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pv1 <= 1'b0;
      px1 <= '0;
      py1 <= '0;
      r1  <= '0;
      ba1 <= '0;
      sa1 <= '0;
      for (int k = 0; k < BALL_NUM; k++) begin
        bdx1[k] <= '0;
        bdy1[k] <= '0;
      end
      for (int k = 0; k < SHOT_NUM; k++) begin
        sdx1[k] <= '0;
        sdy1[k] <= '0;
      end
    end else begin
      pv1 <= pix_valid;
      px1 <= px;
      py1 <= py;
      r1  <= snap_r;
      ba1 <= snap_ba;
      sa1 <= snap_sa;
      for (int k = 0; k < BALL_NUM; k++) begin
        bdx1[k] <= absdiff(px, snap_bx[k*10 +: 10]);
        bdy1[k] <= absdiff(py, snap_by[k*10 +: 10]);
      end
      for (int k = 0; k < SHOT_NUM; k++) begin
        sdx1[k] <= absdiff(px, snap_sx[k*10 +: 10]);
        sdy1[k] <= absdiff(py, snap_sy[k*10 +: 10]);
      end
    end
  end

  // Stage 2: full-width squares and shot box membership
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pv2   <= 1'b0;
      px2   <= '0;
      py2   <= '0;
      rr2   <= '0;
      ba2   <= '0;
      s_in2 <= '0;
      for (int k = 0; k < BALL_NUM; k++) sum2[k] <= '0;
    end else begin
      pv2 <= pv1;
      px2 <= px1;
      py2 <= py1;
      rr2 <= 12'(r1) * 12'(r1);
      ba2 <= ba1;
      for (int k = 0; k < BALL_NUM; k++)
        sum2[k] <= 21'(bdx1[k]) * 21'(bdx1[k]) + 21'(bdy1[k]) * 21'(bdy1[k]);
      for (int k = 0; k < SHOT_NUM; k++)
        s_in2[k] <= sa1[k] && (sdx1[k] <= SHW) && (sdy1[k] <= SHH);
    end
  end

  // Stage 3 logic: disc test (edge inclusive) and lowest-index priority encode
  always_comb begin
    b_idx3 = '0;
    s_idx3 = 1'b0;
    for (int k = 0; k < BALL_NUM; k++)
      b_in3[k] = ba2[k] && (sum2[k] <= {9'd0, rr2});
    for (int k = BALL_NUM - 1; k >= 0; k--)
      if (b_in3[k]) b_idx3 = 2'(k);
    for (int k = SHOT_NUM - 1; k >= 0; k--)
      if (s_in2[k]) s_idx3 = 1'(k);
  end

  // Stage 3 registers: hits forced to 0 on bubbles, coordinates hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      o_px      <= '0;
      o_py      <= '0;
      ball_hit  <= 1'b0;
      ball_idx  <= '0;
      shot_hit  <= 1'b0;
      shot_idx  <= 1'b0;
    end else begin
      out_valid <= pv2;
      if (pv2) begin
        o_px <= px2;
        o_py <= py2;
      end
      ball_hit <= pv2 && (|b_in3);
      ball_idx <= pv2 ? b_idx3 : 2'd0;
      shot_hit <= pv2 && (|s_in2);
      shot_idx <= pv2 ? s_idx3 : 1'b0;
    end
  end

  // Per-frame visibility: publish on frame_start, hits that cycle start the new frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen_acc <= '0;
      b_seen   <= '0;
    end else if (frame_start) begin
      b_seen   <= seen_acc;
      seen_acc <= pv2 ? b_in3 : '0;
    end else if (pv2) begin
      seen_acc <= seen_acc | b_in3;
    end
  end

endmodule

// File: tb/tb_object_renderer.sv
// Directed bench for object_renderer: drives pixels and frame pulses, checks
// hit flags, indices, coordinates and per-frame visibility against hand values.
module tb_object_renderer;

  logic        clock;
  logic        reset;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  px, py;
  logic [5:0]  radius;
  logic [29:0] i_bx, i_by;
  logic [2:0]  b_active;
  logic [19:0] i_sx, i_sy;
  logic [1:0]  s_active;
  logic        out_valid;
  logic [9:0]  o_px, o_py;
  logic        ball_hit;
  logic [1:0]  ball_idx;
  logic        shot_hit;
  logic        shot_idx;
  logic [2:0]  b_seen;

  int checks = 0;
  int errors = 0;

  object_renderer #(.BALL_NUM(3), .SHOT_NUM(2), .SHOT_HW(2), .SHOT_HH(6)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .px(px), .py(py), .radius(radius), .i_bx(i_bx), .i_by(i_by), .b_active(b_active),
    .i_sx(i_sx), .i_sy(i_sy), .s_active(s_active), .out_valid(out_valid),
    .o_px(o_px), .o_py(o_py), .ball_hit(ball_hit), .ball_idx(ball_idx),
    .shot_hit(shot_hit), .shot_idx(shot_idx), .b_seen(b_seen)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Present one pixel and wait until it reaches the outputs
  task automatic send_pixel(input logic [9:0] x, input logic [9:0] y);
    pix_valid = 1'b1;
    px = x;
    py = y;
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    px = '0;
    py = '0;
    radius = '0;
    i_bx = '0;
    i_by = '0;
    b_active = '0;
    i_sx = '0;
    i_sy = '0;
    s_active = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_b_seen", 32'(b_seen), 0);
    check("rst_ball_hit", 32'(ball_hit), 0);
    reset = 1'b0;
    tick();

    // No hits before the first frame_start even with inputs set up
    radius = 6'd20;
    i_bx = {10'd0, 10'd0, 10'd320};
    i_by = {10'd0, 10'd0, 10'd240};
    b_active = 3'b001;
    send_pixel(10'd320, 10'd240);
    check("pre_frame_valid", 32'(out_valid), 1);
    check("pre_frame_hit", 32'(ball_hit), 0);

    // Horizontal edge of r=20 disc at (320,240)
    pulse_frame();
    send_pixel(10'd340, 10'd240);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_edge_hit", 32'(ball_hit), 1);
    check("t1_edge_idx", 32'(ball_idx), 0);
    check("t1_o_px", 32'(o_px), 340);
    check("t1_o_py", 32'(o_py), 240);
    tick();
    check("bubble_valid", 32'(out_valid), 0);
    check("bubble_hit", 32'(ball_hit), 0);
    check("bubble_px_hold", 32'(o_px), 340);
    send_pixel(10'd341, 10'd240);
    check("t1_outside", 32'(ball_hit), 0);

    // Diagonal edge: 144+256=400 inside, 169+256=425 outside
    send_pixel(10'd332, 10'd256);
    check("t2_diag_in", 32'(ball_hit), 1);
    send_pixel(10'd333, 10'd256);
    check("t2_diag_out", 32'(ball_hit), 0);

    // Overlapping balls 0 and 2 at (100,100)
    i_bx = {10'd100, 10'd500, 10'd100};
    i_by = {10'd100, 10'd400, 10'd100};
    b_active = 3'b101;
    pulse_frame();
    send_pixel(10'd100, 10'd100);
    check("t3_overlap_hit", 32'(ball_hit), 1);
    check("t3_overlap_idx0", 32'(ball_idx), 0);
    b_active = 3'b100;
    pulse_frame();
    send_pixel(10'd100, 10'd100);
    check("t3_idx2", 32'(ball_idx), 2);

    // radius 0 covers only the centre pixel
    radius = 6'd0;
    pulse_frame();
    send_pixel(10'd100, 10'd100);
    check("r0_centre", 32'(ball_hit), 1);
    send_pixel(10'd101, 10'd100);
    check("r0_adjacent", 32'(ball_hit), 0);

    // Mid-frame position change is ignored until frame_start
    radius = 6'd20;
    pulse_frame();
    i_bx = {10'd300, 10'd500, 10'd100};
    send_pixel(10'd100, 10'd100);
    check("t4_old_pos", 32'(ball_hit), 1);
    check("t4_old_idx", 32'(ball_idx), 2);
    // Pixel coincident with frame_start uses the old snapshot
    frame_start = 1'b1;
    pix_valid = 1'b1;
    px = 10'd100;
    py = 10'd100;
    tick();
    frame_start = 1'b0;
    pix_valid = 1'b0;
    tick();
    tick();
    check("t4_coincident_old", 32'(ball_hit), 1);
    send_pixel(10'd100, 10'd100);
    check("t4_new_pos_miss", 32'(ball_hit), 0);
    send_pixel(10'd300, 10'd100);
    check("t4_new_pos_hit", 32'(ball_hit), 1);

    // Shots: shot0 (50,400), shot1 (600,10); ball0 at (60,406) r=20
    i_bx = {10'd0, 10'd0, 10'd60};
    i_by = {10'd0, 10'd0, 10'd406};
    b_active = 3'b001;
    i_sx = {10'd600, 10'd50};
    i_sy = {10'd10, 10'd400};
    s_active = 2'b11;
    pulse_frame();
    send_pixel(10'd52, 10'd406);
    check("t5_shot_corner", 32'(shot_hit), 1);
    check("t5_shot_idx0", 32'(shot_idx), 0);
    check("t5_both_ball", 32'(ball_hit), 1);
    send_pixel(10'd53, 10'd400);
    check("t5_shot_out", 32'(shot_hit), 0);
    check("t5_shot_out_idx", 32'(shot_idx), 0);
    send_pixel(10'd602, 10'd16);
    check("t5_shot1_hit", 32'(shot_hit), 1);
    check("t5_shot1_idx", 32'(shot_idx), 1);

    // Visibility: last frame only ball0 was hit
    i_bx = {10'd0, 10'd200, 10'd659};
    i_by = {10'd0, 10'd200, 10'd50};
    b_active = 3'b011;
    s_active = 2'b00;
    pulse_frame();
    check("t6_seen_prev", 32'(b_seen), 1);
    send_pixel(10'd200, 10'd200);
    check("t6_ball1_hit", 32'(ball_hit), 1);
    check("t6_ball1_idx", 32'(ball_idx), 1);
    send_pixel(10'd638, 10'd50);
    check("t6_offscreen_miss", 32'(ball_hit), 0);
    pulse_frame();
    check("t6_seen_010", 32'(b_seen), 3'b010);

    // Mid-frame reset clears outputs asynchronously
    send_pixel(10'd200, 10'd200);
    check("t6_pre_rst_valid", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(out_valid), 0);
    check("t6_async_seen", 32'(b_seen), 0);
    check("t6_async_hit", 32'(ball_hit), 0);
    tick();
    reset = 1'b0;
    tick();
    pulse_frame();
    check("t6_acc_cleared", 32'(b_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
